ahb_ram_arbiter: RTL and testbench
==================================

Name: ahb_ram_arbiter

Overview:
- Two-requester arbiter that shares the single AHB RAM slave (ram_top) between the instruction-fetch port (m0) and the load/store port (m1).
- Captures one request at a time, drives the slave-side AHB signals, waits for slave hready, then returns read data and response to the owning master.
- Sits between the core's two memory ports and ram_top; round-robin fairness.

Parameters:
- ADDR_WIDTH, 32, address width (matches `AHB_ADDR_WIDTH)
- DATA_WIDTH, 32, data width (matches `AHB_DATA_WIDTH)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- m0_hsel  input  1  m0 request; hold high with command stable until m0_hready
- m0_haddr  input  ADDR_WIDTH  m0 address
- m0_hwrite  input  1  m0 write=1, read=0
- m0_hwdata  input  DATA_WIDTH  m0 write data
- m0_hready  output  1  one-cycle completion pulse to m0
- m0_hresp  output  1  m0 response, 0=OKAY, 1=ERROR; valid with m0_hready
- m0_hrdata  output  DATA_WIDTH  m0 read data; valid with m0_hready
- m1_*  same seven signals as m0_* for requester m1
- s_hsel  output  1  slave select to ram_top
- s_haddr  output  ADDR_WIDTH  slave address
- s_hwrite  output  1  slave write
- s_hwdata  output  DATA_WIDTH  slave write data
- s_hready  input  1  slave transfer done
- s_hresp  input  1  slave response
- s_hrdata  input  DATA_WIDTH  slave read data

Behaviour:
- Reset: async on rstn low. All outputs are 0: s_hsel, s_haddr, s_hwrite, s_hwdata, mN_hready, mN_hresp, mN_hrdata. FSM goes to IDLE. RR pointer rr_last=1, so m0 wins first.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any mN_hsel is high, pick the winner, register its haddr/hwrite/hwdata into s_* and set s_hsel=1.
  - Record owner and go to BUSY.
  - Winner with one requester: that requester.
  - Winner with both requesting: the one not equal to rr_last.
  - rr_last updates to the winner on grant.
- BUSY:
  - s_* are held stable.
  - On s_hready=1, deassert s_hsel and latch s_hrdata/s_hresp into owner's mN_hrdata/mN_hresp. Pulse owner's mN_hready=1 in the next cycle (RESP).
  - s_hresp=1 propagates as mN_hresp=1.
- RESP: mN_hready high exactly one cycle, then mN_hready=0 and go to IDLE.
- mN_hrdata/mN_hresp hold their last value until the next completion to that master.
- Non-owner's hready stays 0 throughout.
- Latency: request sampled at cycle 0, s_hsel high at cycle 1, s_hready at cycle k≥1, mN_hready at cycle k+1. Minimum 3 cycles request-to-done. One transfer per k+2 cycles back-to-back.
- Master must drop hsel in the cycle after its hready. If hsel is still high when IDLE samples it, it is treated as a new request.
- mN_hsel dropping during BUSY is ignored; the captured transfer completes.
- s_hready while in IDLE/RESP is ignored.
- Loser keeps hsel high and is served next (RR guarantees ≤1 waiting transfer).
- Reset mid-transfer: s_hsel drops immediately (async), no hready pulse is issued, and the pending request is lost. Masters reissue after reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on BUSY entry, increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no s_hready: drop s_hsel, go to RESP, owner gets hready=1, hresp=1, hrdata=0.
  - A late s_hready is ignored.
- Not defined: no counter; BUSY waits indefinitely.

Test Plan:
- Single read: m0_hsel=1, haddr=0x100; slave returns hrdata=0xDEADBEEF, hready 2 cycles after s_hsel -> s_haddr=0x100 and s_hwrite=0 at cycle 1; m0_hready pulses one cycle with m0_hrdata=0xDEADBEEF, m0_hresp=0; m1_hready stays 0.
- Simultaneous requests: m0 read 0x10 and m1 write 0x20/0x12345678 asserted the same cycle after reset -> m0 served first, then m1 with s_hwdata=0x12345678. Repeat both -> order m0,m1 again, alternating on each contention.
- Back-to-back contention: m1 continuously requesting and m0 requesting after each completion -> grants strictly alternate, no master gets two consecutive grants while the other waits.
- Error: slave s_hresp=1 on m1 write -> m1_hresp=1 with m1_hready pulse.
- Reset mid-BUSY: rstn low during an m0 transfer -> all outputs 0 within the reset assertion; after release, m0 is granted first and no stale hready appears.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): s_hready held 0 -> s_hsel drops after 8 BUSY cycles, owner sees hready=1, hresp=1, hrdata=0. Without the macro, s_hsel stays high indefinitely.

Source files
------------

// File: rtl/ahb_ram_arbiter.sv
// Round-robin arbiter sharing one AHB RAM slave between m0 (fetch) and m1 (load/store).
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_hsel,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic                  m0_hwrite,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  input  logic                  m1_hsel,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic                  m1_hwrite,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  s_hsel,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic                  s_hwrite,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic                  s_hready,
  input  logic                  s_hresp,
  input  logic [DATA_WIDTH-1:0] s_hrdata
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    rr_last_q, rr_last_d;
  logic                    s_hsel_q, s_hsel_d;
  logic [ADDR_WIDTH-1:0]   s_haddr_q, s_haddr_d;
  logic                    s_hwrite_q, s_hwrite_d;
  logic [DATA_WIDTH-1:0]   s_hwdata_q, s_hwdata_d;
  logic [1:0]              hready_q, hready_d;
  logic [1:0]              hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]   hrdata_q [2];
  logic [DATA_WIDTH-1:0]   hrdata_d [2];
  logic                    win_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    s_hsel_d   = s_hsel_q;
    s_haddr_d  = s_haddr_q;
    s_hwrite_d = s_hwrite_q;
    s_hwdata_d = s_hwdata_q;
    hready_d   = 2'b00;
    hresp_d    = hresp_q;
    hrdata_d   = hrdata_q;
    win_c      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (m0_hsel || m1_hsel) begin
          // On contention the requester that did not win last time gets the slot
          win_c      = (m0_hsel && m1_hsel) ? ~rr_last_q : m1_hsel;
          owner_d    = win_c;
          rr_last_d  = win_c;
          s_hsel_d   = 1'b1;
          s_haddr_d  = win_c ? m1_haddr  : m0_haddr;
          s_hwrite_d = win_c ? m1_hwrite : m0_hwrite;
          s_hwdata_d = win_c ? m1_hwdata : m0_hwdata;
          state_d    = BUSY;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (s_hready) begin
          s_hsel_d          = 1'b0;
          hrdata_d[owner_q] = s_hrdata;
          hresp_d[owner_q]  = s_hresp;
          hready_d[owner_q] = 1'b1;
          state_d           = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          s_hsel_d          = 1'b0;
          hrdata_d[owner_q] = '0;
          hresp_d[owner_q]  = 1'b1;
          hready_d[owner_q] = 1'b1;
          state_d           = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      s_hsel_q    <= 1'b0;
      s_haddr_q   <= '0;
      s_hwrite_q  <= 1'b0;
      s_hwdata_q  <= '0;
      hready_q    <= 2'b00;
      hresp_q     <= 2'b00;
      hrdata_q[0] <= '0;
      hrdata_q[1] <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      s_hsel_q    <= s_hsel_d;
      s_haddr_q   <= s_haddr_d;
      s_hwrite_q  <= s_hwrite_d;
      s_hwdata_q  <= s_hwdata_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      hrdata_q[0] <= hrdata_d[0];
      hrdata_q[1] <= hrdata_d[1];
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign s_hsel    = s_hsel_q;
  assign s_haddr   = s_haddr_q;
  assign s_hwrite  = s_hwrite_q;
  assign s_hwdata  = s_hwdata_q;
  assign m0_hready = hready_q[0];
  assign m1_hready = hready_q[1];
  assign m0_hresp  = hresp_q[0];
  assign m1_hresp  = hresp_q[1];
  assign m0_hrdata = hrdata_q[0];
  assign m1_hrdata = hrdata_q[1];

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Self-checking bench for ahb_ram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_ahb_ram_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    m_hsel = '0;
  logic [1:0]    m_hwrite = '0;
  logic [AW-1:0] m_haddr [2];
  logic [DW-1:0] m_hwdata [2];
  logic          m_hready [2];
  logic          m_hresp [2];
  logic [DW-1:0] m_hrdata [2];
  logic          s_hsel, s_hwrite;
  logic [AW-1:0] s_haddr;
  logic [DW-1:0] s_hwdata;
  logic          s_hready = 1'b0;
  logic          s_hresp = 1'b0;
  logic [DW-1:0] s_hrdata = '0;

  // Reference model: pending requests, their commands, round-robin history, last responses
  bit            req [2];
  logic [AW-1:0] r_addr [2];
  logic          r_write [2];
  logic [DW-1:0] r_wdata [2];
  int            rr_last;
  logic [DW-1:0] last_rdata [2];
  logic          last_resp [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_hsel(m_hsel[0]), .m0_haddr(m_haddr[0]), .m0_hwrite(m_hwrite[0]), .m0_hwdata(m_hwdata[0]),
    .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]), .m0_hrdata(m_hrdata[0]),
    .m1_hsel(m_hsel[1]), .m1_haddr(m_haddr[1]), .m1_hwrite(m_hwrite[1]), .m1_hwdata(m_hwdata[1]),
    .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]), .m1_hrdata(m_hrdata[1]),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0;
      last_rdata[m] = '0;
      last_resp[m] = 1'b0;
    end
    rr_last = 1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_hsel"}, 32'(s_hsel), 32'd0);
    chk({tag, "_s_haddr"}, s_haddr, 32'd0);
    chk({tag, "_s_hwrite"}, 32'(s_hwrite), 32'd0);
    chk({tag, "_s_hwdata"}, s_hwdata, 32'd0);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_hready", tag, m), 32'(m_hready[m]), 32'd0);
      chk($sformatf("%s_m%0d_hresp", tag, m), 32'(m_hresp[m]), 32'd0);
      chk($sformatf("%s_m%0d_hrdata", tag, m), m_hrdata[m], 32'd0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    m_hsel = '0;
    s_hready = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req[m] = 1'b1;
    r_addr[m] = a;
    r_write[m] = w;
    r_wdata[m] = d;
  endtask

  // One arbitration round: present pending requests, serve the expected winner with latency k
  task automatic run_txn(input int k, input logic [DW-1:0] rd, input logic rsp);
    int w;
    int kend;
    logic [DW-1:0] exp_rd;
    logic exp_rsp;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      m_hsel[m] = req[m];
      if (req[m]) begin
        m_haddr[m] = r_addr[m];
        m_hwrite[m] = r_write[m];
        m_hwdata[m] = r_wdata[m];
      end
    end
    s_hready = 1'($urandom_range(0, 1));
    s_hrdata = $urandom;
    s_hresp = 1'($urandom_range(0, 1));
    if (!req[0] && !req[1]) begin
      @(posedge clk); #1;
      chk("idle_s_hsel", 32'(s_hsel), 32'd0);
      chk("idle_m0_hready", 32'(m_hready[0]), 32'd0);
      chk("idle_m1_hready", 32'(m_hready[1]), 32'd0);
      return;
    end
    w = (req[0] && req[1]) ? 1 - rr_last : (req[0] ? 0 : 1);
    rr_last = w;
    @(posedge clk); #1;
    chk("grant_s_hsel", 32'(s_hsel), 32'd1);
    chk("grant_s_haddr", s_haddr, r_addr[w]);
    chk("grant_s_hwrite", 32'(s_hwrite), 32'(r_write[w]));
    chk("grant_s_hwdata", s_hwdata, r_wdata[w]);
    kend = (TMO_EN && k > int'(TMO)) ? int'(TMO) : k;
    for (int c = 1; c <= kend; c++) begin
      @(negedge clk);
      s_hready = (c == k);
      s_hrdata = (c == k) ? rd : $urandom;
      s_hresp = (c == k) ? rsp : 1'($urandom_range(0, 1));
      if (c == 1 && $urandom_range(0, 1) == 1) m_hsel[w] = 1'b0;
      @(posedge clk); #1;
      if (c < kend) begin
        chk("busy_s_hsel", 32'(s_hsel), 32'd1);
        chk("busy_s_haddr", s_haddr, r_addr[w]);
        chk("busy_m0_hready", 32'(m_hready[0]), 32'd0);
        chk("busy_m1_hready", 32'(m_hready[1]), 32'd0);
      end
    end
    exp_rd = (kend < k) ? '0 : rd;
    exp_rsp = (kend < k) ? 1'b1 : rsp;
    last_rdata[w] = exp_rd;
    last_resp[w] = exp_rsp;
    chk("done_s_hsel", 32'(s_hsel), 32'd0);
    chk("done_owner_hready", 32'(m_hready[w]), 32'd1);
    chk("done_other_hready", 32'(m_hready[1 - w]), 32'd0);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("done_m%0d_hrdata", m), m_hrdata[m], last_rdata[m]);
      chk($sformatf("done_m%0d_hresp", m), 32'(m_hresp[m]), 32'(last_resp[m]));
    end
    req[w] = 1'b0;
    @(negedge clk);
    m_hsel[w] = 1'b0;
    s_hready = 1'($urandom_range(0, 1));
    s_hrdata = $urandom;
    s_hresp = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("after_s_hsel", 32'(s_hsel), 32'd0);
    chk("after_m0_hready", 32'(m_hready[0]), 32'd0);
    chk("after_m1_hready", 32'(m_hready[1]), 32'd0);
    chk("after_owner_hrdata", m_hrdata[w], last_rdata[w]);
  endtask

  initial begin
    m_haddr[0] = '0; m_haddr[1] = '0;
    m_hwdata[0] = '0; m_hwdata[1] = '0;
    model_reset();

    apply_reset();

    // Single read from m0
    set_req(0, 32'h100, 1'b0, 32'h0);
    run_txn(2, 32'hDEADBEEF, 1'b0);

    // Simultaneous requests after reset: m0 first, then m1; repeated
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 32'h10, 1'b0, 32'h0);
      set_req(1, 32'h20, 1'b1, 32'h12345678);
      run_txn(1, 32'hA5A5_0000 + 32'(r), 1'b0);
      run_txn(3, 32'h5A5A_0000 + 32'(r), 1'b0);
    end

    // Slave error on m1 write
    set_req(1, 32'h44, 1'b1, 32'hCAFEF00D);
    run_txn(1, 32'h0BAD_0BAD, 1'b1);

    // Back-to-back contention: both re-request after every completion
    for (int r = 0; r < 6; r++) begin
      if (!req[0]) set_req(0, 32'h1000 + 32'(r), 1'b0, 32'h0);
      if (!req[1]) set_req(1, 32'h2000 + 32'(r), 1'b1, $urandom);
      run_txn(int'($urandom_range(1, 3)), $urandom, 1'b0);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    m_hsel = '0;

    // Reset in the middle of an m0 transfer
    @(negedge clk);
    m_hsel[0] = 1'b1; m_haddr[0] = 32'h300; m_hwrite[0] = 1'b0;
    s_hready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_grant", 32'(s_hsel), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    @(negedge clk);
    m_hsel = '0;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("postrst_s_hsel", 32'(s_hsel), 32'd0);
      chk("postrst_m0_hready", 32'(m_hready[0]), 32'd0);
      chk("postrst_m1_hready", 32'(m_hready[1]), 32'd0);
    end
    set_req(0, 32'h400, 1'b0, 32'h0);
    set_req(1, 32'h500, 1'b1, 32'h77);
    run_txn(1, 32'h1111_2222, 1'b0);
    run_txn(2, 32'h3333_4444, 1'b0);

    // Slave never responds within the watchdog window
    set_req(1, 32'h600, 1'b0, 32'h0);
    run_txn(12, 32'h9999_9999, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 2) != 0)
          set_req(m, $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      run_txn(int'($urandom_range(1, 5)), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
